instr_cache: RTL and testbench

- Direct-mapped, read-only instruction cache between the CPU fetch port (PC) and a multi-cycle block-read instruction memory.
- Replaces the zero-state combinational fetch path.
- Hits return the 32-bit instruction in the same cycle.
- Misses stall the CPU via BUSYWAIT while a 16-byte block is fetched from instruction memory and installed.

---
 rtl/icache_pkg.sv | 21 ++
 rtl/instr_cache_if.sv | 26 ++
 rtl/icache_line_store.sv | 46 ++++
 rtl/instr_cache.sv | 109 ++++++++++
 tb/tb_instr_cache.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// State encoding matches the data-cache FSM.
package icache_pkg;

  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_BYTES = 16;
  localparam int ADDR_W      = 10;
  localparam int TAG_W       = 3;
  localparam int INDEX_W     = 3;
  localparam int OFFSET_W    = 4;
  localparam int BLOCK_W     = 128;
  localparam int WORD_W      = 32;
  localparam int MADDR_W     = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    IC_IDLE     = 2'd0,
    IC_MEM_READ = 2'd1,
    IC_UPDATE   = 2'd2
  } ic_state_e;

endpackage

// File: rtl/instr_cache_if.sv
// CPU fetch port and instruction-memory block port of the instruction cache.
interface instr_cache_if;
  import icache_pkg::*;

  logic                 read;
  logic [ADDR_W-1:0]    address;
  logic [WORD_W-1:0]    instruction;
  logic                 busywait;
  logic                 mem_read;
  logic [MADDR_W-1:0]   mem_address;
  logic [BLOCK_W-1:0]   mem_readdata;
  logic                 mem_busywait;

  // Cache side.
  modport slave (
    input  read, address, mem_readdata, mem_busywait,
    output instruction, busywait, mem_read, mem_address
  );

  // CPU / memory environment side.
  modport master (
    output read, address, mem_readdata, mem_busywait,
    input  instruction, busywait, mem_read, mem_address
  );

endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: async valid clear, one synchronous line write,
// combinational read of a single line.
module icache_line_store
  import icache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [BLOCK_W-1:0] wr_data_i,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [BLOCK_W-1:0] rd_data_o
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

  generate
    for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_valid
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          valid_q[gi] <= 1'b0;
        end else if (wr_en_i && (wr_index_i == INDEX_W'(gi))) begin
          valid_q[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Tag and data survive reset; only the valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, block fill
// from instruction memory on a miss while the CPU is stalled.
module instr_cache
  import icache_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  instr_cache_if.slave  bus
);

  ic_state_e            state_q, state_d;
  logic [MADDR_W-1:0]   miss_addr_q, miss_addr_d;
  logic [BLOCK_W-1:0]   block_q, block_d;

  logic [TAG_W-1:0]     req_tag;
  logic [INDEX_W-1:0]   req_index;
  logic [1:0]           req_word;
  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [BLOCK_W-1:0]   rd_data;
  logic                 hit;
  logic                 wr_en;
  logic                 busywait;
  logic                 mem_read;
  logic [MADDR_W-1:0]   mem_address;
  logic [WORD_W-1:0]    instruction;
  logic                 unused_byte_bits;

  assign req_tag          = bus.address[ADDR_W-1 -: TAG_W];
  assign req_index        = bus.address[OFFSET_W +: INDEX_W];
  assign req_word         = bus.address[OFFSET_W-1:2];
  assign unused_byte_bits = ^bus.address[1:0];

  icache_line_store u_store (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en),
    .wr_index_i (miss_addr_q[INDEX_W-1:0]),
    .wr_tag_i   (miss_addr_q[MADDR_W-1 -: TAG_W]),
    .wr_data_i  (block_q),
    .rd_index_i (req_index),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data)
  );

  assign hit = bus.read & rd_valid & (rd_tag == req_tag);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IC_IDLE;
      miss_addr_q <= '0;
      block_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      block_q     <= block_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    block_d     = block_q;
    wr_en       = 1'b0;
    busywait    = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    instruction = '0;
    case (state_q)
      IC_IDLE: begin
        instruction = rd_data[{req_word, 5'b0} +: WORD_W];
        if (bus.read && !hit) begin
          busywait    = 1'b1;
          state_d     = IC_MEM_READ;
          miss_addr_d = {req_tag, req_index};
        end
      end
      IC_MEM_READ: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = miss_addr_q;
        if (!bus.mem_busywait) begin
          block_d = bus.mem_readdata;
          state_d = IC_UPDATE;
        end
      end
      IC_UPDATE: begin
        busywait = 1'b1;
        wr_en    = 1'b1;
        state_d  = IC_IDLE;
      end
      default: state_d = IC_IDLE;
    endcase
    // Keep the CPU and memory sides quiet for the whole reset pulse.
    if (rst_i) begin
      busywait    = 1'b0;
      mem_read    = 1'b0;
      mem_address = '0;
      instruction = '0;
    end
  end

  assign bus.busywait    = busywait;
  assign bus.mem_read    = mem_read;
  assign bus.mem_address = mem_address;
  assign bus.instruction = instruction;

endmodule

// File: tb/tb_instr_cache.sv
// Bench for instr_cache: table vectors, reset/toggle/idle sequences and
// random fetches checked against a line-level cache model.
module tb_instr_cache;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_cache_if bus();

  instr_cache dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction memory: byte array, fixed latency counted in MEM_READ cycles.
  logic [7:0]   mem_bytes [1024];
  int           mem_lat = 4;
  int           mem_cnt = 0;
  logic [127:0] rdata;

  always @(posedge clk) begin
    if (bus.mem_read) mem_cnt <= mem_cnt + 1;
    else              mem_cnt <= 0;
  end
  assign bus.mem_busywait = (mem_cnt + 1 < mem_lat);
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 16; i++) rdata[8*i +: 8] = mem_bytes[{bus.mem_address, 4'(i)}];
  end
  assign bus.mem_readdata = rdata;

  // Reference cache: which block each line holds.
  bit         m_valid [8];
  logic [2:0] m_tag   [8];

  function automatic logic [31:0] exp_word(input logic [9:0] a);
    return {mem_bytes[{a[9:2], 2'd3}], mem_bytes[{a[9:2], 2'd2}],
            mem_bytes[{a[9:2], 2'd1}], mem_bytes[{a[9:2], 2'd0}]};
  endfunction

  function automatic bit model_hit(input logic [9:0] a);
    return m_valid[a[6:4]] && (m_tag[a[6:4]] == a[9:7]);
  endfunction

  task automatic model_fill(input logic [9:0] a);
    m_valid[a[6:4]] = 1'b1;
    m_tag[a[6:4]]   = a[9:7];
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with the cache back in IDLE.
  task automatic fetch(input logic [9:0] a, input int lat, output int bw,
                       output logic [5:0] ma, output logic mr, output logic [31:0] ins);
    mem_lat     = lat;
    bus.address = a;
    bus.read    = 1'b1;
    bw = 0; ma = '0; mr = 1'b0;
    @(negedge clk);
    while (bus.busywait && bw < 50) begin
      bw++;
      if (bus.mem_read) begin
        mr = 1'b1;
        ma = bus.mem_address;
      end
      @(negedge clk);
    end
    ins = bus.instruction;
    @(posedge clk); #1;
  endtask

  task automatic run_fetch(input string nm, input logic [9:0] a, input int lat);
    int         bw;
    logic [5:0] ma;
    logic       mr;
    logic [31:0] ins;
    bit         h;
    h = model_hit(a);
    fetch(a, lat, bw, ma, mr, ins);
    chk({nm, "_bw"}, 128'(bw), h ? 128'd0 : 128'(lat + 2));
    chk({nm, "_mr"}, 128'(mr), 128'(!h));
    if (!h) chk({nm, "_maddr"}, 128'(ma), 128'(a[9:4]));
    chk({nm, "_instr"}, 128'(ins), 128'(exp_word(a)));
    model_fill(a);
    $display("fetch %s addr=%h lat=%0d busy=%0d maddr=%h instr=%h", nm, a, lat, bw, ma, ins);
  endtask

  typedef struct {
    logic [9:0] addr;
    int         lat;
    int         exp_bw;
    logic [5:0] exp_maddr;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [7];
    int          bw;
    logic [5:0]  ma;
    logic        mr;
    logic [31:0] ins;
    logic [9:0]  a;
    int          lat;
    int          guard;

    for (int i = 0; i < 1024; i++) mem_bytes[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_tag[i] = '0; end

    vecs[0] = '{10'h000, 4, 6, 6'h00};
    vecs[1] = '{10'h004, 4, 0, 6'h00};
    vecs[2] = '{10'h008, 2, 0, 6'h00};
    vecs[3] = '{10'h00C, 3, 0, 6'h00};
    vecs[4] = '{10'h010, 2, 4, 6'h01};
    vecs[5] = '{10'h090, 1, 3, 6'h09};
    vecs[6] = '{10'h010, 5, 7, 6'h01};

    // Outputs held quiet during reset even with READ high.
    bus.read = 1'b1;
    bus.address = 10'h000;
    @(negedge clk); @(negedge clk);
    chk("reset_busywait", 128'(bus.busywait), 128'd0);
    chk("reset_mem_read", 128'(bus.mem_read), 128'd0);
    chk("reset_mem_addr", 128'(bus.mem_address), 128'd0);
    chk("reset_instr",    128'(bus.instruction), 128'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      fetch(vecs[i].addr, vecs[i].lat, bw, ma, mr, ins);
      chk($sformatf("vec%0d_bw", i), 128'(bw), 128'(vecs[i].exp_bw));
      chk($sformatf("vec%0d_mr", i), 128'(mr), 128'(vecs[i].exp_bw != 0));
      if (vecs[i].exp_bw != 0) chk($sformatf("vec%0d_maddr", i), 128'(ma), 128'(vecs[i].exp_maddr));
      chk($sformatf("vec%0d_instr", i), 128'(ins), 128'(exp_word(vecs[i].addr)));
      model_fill(vecs[i].addr);
      $display("vec %0d addr=%h busy=%0d maddr=%h instr=%h", i, vecs[i].addr, bw, ma, ins);
    end

    // Reset two cycles into a miss abandons the fill.
    mem_lat = 4;
    bus.address = 10'h3FC;
    @(negedge clk);
    chk("rstmid_bw_rise", 128'(bus.busywait), 128'd1);
    @(negedge clk);
    chk("rstmid_mem_read", 128'(bus.mem_read), 128'd1);
    chk("rstmid_mem_addr", 128'(bus.mem_address), 128'h3F);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_mr_drop", 128'(bus.mem_read), 128'd0);
    chk("rstmid_bw_drop", 128'(bus.busywait), 128'd0);
    chk("rstmid_maddr0",  128'(bus.mem_address), 128'd0);
    chk("rstmid_instr0",  128'(bus.instruction), 128'd0);
    $display("reset mid-miss addr=3fc mem_read=%0d busywait=%0d", bus.mem_read, bus.busywait);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    run_fetch("after_rst_3fc", 10'h3FC, 4);
    run_fetch("after_rst_000", 10'h000, 2);

    // ADDRESS glitching during the fill must not redirect it.
    mem_lat = 3;
    bus.address = 10'h020;
    @(negedge clk);
    chk("toggle_bw", 128'(bus.busywait), 128'd1);
    @(posedge clk); #1 bus.address = 10'h200;
    guard = 0;
    @(negedge clk);
    while (bus.mem_read && guard < 50) begin
      chk("toggle_maddr", 128'(bus.mem_address), 128'h02);
      guard++;
      @(negedge clk);
    end
    chk("toggle_mr_cycles", 128'(guard), 128'd3);
    bus.address = 10'h020;
    @(negedge clk);
    chk("toggle_bw_drop", 128'(bus.busywait), 128'd0);
    chk("toggle_instr",   128'(bus.instruction), 128'(exp_word(10'h020)));
    $display("toggle fill addr=020 mem_read_cycles=%0d instr=%h", guard, bus.instruction);
    model_fill(10'h020);
    @(posedge clk); #1;
    run_fetch("toggle_idx0", 10'h004, 1);

    // READ=0 starts nothing, even on an address that would miss.
    bus.read = 1'b0;
    bus.address = 10'h3C0;
    guard = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.busywait || bus.mem_read) guard++;
    end
    chk("read0_quiet", 128'(guard), 128'd0);
    $display("read0 addr=3c0 active_cycles=%0d", guard);
    @(posedge clk); #1;
    run_fetch("read0_then_hit", 10'h008, 2);

    for (int t = 0; t < 40; t++) begin
      a = 10'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) a[9:7] = 3'($urandom_range(0, 7));
      lat = $urandom_range(1, 5);
      run_fetch($sformatf("rnd%0d", t), a, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
